// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and constants for the serial pattern detector
//
// Contents:
//   state_t      detector FSM states (ST_FILL, ST_ARMED)
//   fill_width   width of the fill counter for a given pattern length
//   DEF_PAT_W    default pattern length
//   DEF_PATTERN  default pattern (MSB arrives first)
package seq_det_pkg;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  localparam int DEF_PAT_W = 4;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1011;

  function automatic int fill_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_sat_counter.sv
// rtl/seq_sat_counter.sv - saturating event counter with clear priority
//
// Ports:
//   clk    input   clock, rising edge
//   rst_n  input   asynchronous active-low reset
//   clr    input   synchronous clear, wins over inc
//   inc    input   count one event this edge
//   cnt    output  CNT_W-bit count, sticks at all-ones
module seq_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// rtl/seq_pattern_detector.sv - parametrised serial bit-pattern detector
//
// Optional feature macro: SEQ_DET_CNT_EN (adds cnt_clr/match_cnt and the
// saturating match counter).
//
// Ports:
//   clk        input   clock, rising edge
//   rst_n      input   asynchronous active-low reset
//   din_vld    input   din accepted on this edge when high
//   din        input   serial data bit
//   match      output  registered one-cycle pulse per detected pattern
//   fill       output  valid history bits, saturates at PAT_W
//   cnt_clr    input   synchronous clear of match_cnt (SEQ_DET_CNT_EN only)
//   match_cnt  output  saturating match count (SEQ_DET_CNT_EN only)
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          din_vld,
  input  logic                          din,
  output logic                          match,
  output logic [fill_width(PAT_W)-1:0]  fill
`ifdef SEQ_DET_CNT_EN
  ,
  input  logic                          cnt_clr,
  output logic [CNT_W-1:0]              match_cnt
`endif
);

  localparam int FW = fill_width(PAT_W);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  if (PAT_W < 2 || PAT_W > 32 || CNT_W < 1) begin : g_bad_param
    $error("seq_pattern_detector: illegal PAT_W or CNT_W");
  end

  // Only the youngest PAT_W-1 bits need storing: the oldest bit of a
  // window is consumed in the same cycle the completing bit arrives.
  logic [PAT_W-2:0] hist;
  logic [PAT_W-1:0] hist_nx;
  logic [FW-1:0]    fill_nx;
  logic [FW-1:0]    fill_d;
  logic             hit;
  state_t           state, state_nx;

  always_comb begin
    hist_nx  = {hist, din};
    // Once armed the window is full, so the fill count simply saturates.
    fill_nx  = (state == ST_ARMED) ? FULL : fill + 1'b1;
    hit      = 1'b0;
    fill_d   = fill;
    state_nx = state;
    if (din_vld) begin
      hit    = (fill_nx == FULL) && (hist_nx == PATTERN);
      fill_d = fill_nx;
      if (hit && !OVERLAP) begin
        // Discard history so the next match needs PAT_W brand-new bits.
        fill_d   = '0;
        state_nx = ST_FILL;
      end else if (fill_nx == FULL) begin
        state_nx = ST_ARMED;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FILL;
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else begin
      state <= state_nx;
      fill  <= fill_d;
      match <= hit;
      if (din_vld) begin
        hist <= hist_nx[PAT_W-2:0];
      end
    end
  end

`ifdef SEQ_DET_CNT_EN
  seq_sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (hit),
    .cnt   (match_cnt)
  );
`endif

endmodule

// File: tb/tb_seq_pattern_detector.sv
// tb/tb_seq_pattern_detector.sv - self-checking bench for seq_pattern_detector
module tb_seq_pattern_detector;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din_vld = 1'b0;
  logic din = 1'b0;
  logic cnt_clr = 1'b0;

  logic       m0, m1, m2;
  logic [2:0] f0, f1, f2;
`ifdef SEQ_DET_CNT_EN
  logic [1:0] c0;
  logic [7:0] c1;
  logic [2:0] c2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_pattern_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(2)) u_ov (
    .clk(clk), .rst_n(rst_n), .din_vld(din_vld), .din(din), .match(m0), .fill(f0)
`ifdef SEQ_DET_CNT_EN
    , .cnt_clr(cnt_clr), .match_cnt(c0)
`endif
  );

  seq_pattern_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_no (
    .clk(clk), .rst_n(rst_n), .din_vld(din_vld), .din(din), .match(m1), .fill(f1)
`ifdef SEQ_DET_CNT_EN
    , .cnt_clr(cnt_clr), .match_cnt(c1)
`endif
  );

  seq_pattern_detector #(.PAT_W(6), .PATTERN(6'b110100), .OVERLAP(1'b1), .CNT_W(3)) u_p6 (
    .clk(clk), .rst_n(rst_n), .din_vld(din_vld), .din(din), .match(m2), .fill(f2)
`ifdef SEQ_DET_CNT_EN
    , .cnt_clr(cnt_clr), .match_cnt(c2)
`endif
  );

  // Reference model: a window of the most recent accepted bits per instance.
  int          pw[3]   = '{4, 4, 6};
  logic [31:0] pat[3]  = '{32'b1011, 32'b1011, 32'b110100};
  bit          ov[3]   = '{1'b1, 1'b0, 1'b1};
  int          cmax[3] = '{3, 255, 7};
  bit          mq[3][$];
  bit          mh[3];
  int          mc[3];
  int          pulses[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      mh[i] = 1'b0;
      mc[i] = 0;
    end
  endtask

  task automatic model_update(input bit vld, input bit d, input bit clr);
    for (int i = 0; i < 3; i++) begin
      bit hit;
      hit = 1'b0;
      if (vld) begin
        mq[i].push_back(d);
        if (mq[i].size() > pw[i]) void'(mq[i].pop_front());
        if (mq[i].size() == pw[i]) begin
          hit = 1'b1;
          for (int k = 0; k < pw[i]; k++)
            if (mq[i][k] != pat[i][pw[i]-1-k]) hit = 1'b0;
        end
        if (hit && !ov[i]) mq[i].delete();
      end
      mh[i] = hit;
      if (clr) mc[i] = 0;
      else if (hit && mc[i] < cmax[i]) mc[i]++;
    end
  endtask

  task automatic check_outputs();
    check("u_ov.match", 32'(m0), 32'(mh[0]));
    check("u_ov.fill",  32'(f0), 32'(mq[0].size()));
    check("u_no.match", 32'(m1), 32'(mh[1]));
    check("u_no.fill",  32'(f1), 32'(mq[1].size()));
    check("u_p6.match", 32'(m2), 32'(mh[2]));
    check("u_p6.fill",  32'(f2), 32'(mq[2].size()));
`ifdef SEQ_DET_CNT_EN
    check("u_ov.cnt", 32'(c0), 32'(mc[0]));
    check("u_no.cnt", 32'(c1), 32'(mc[1]));
    check("u_p6.cnt", 32'(c2), 32'(mc[2]));
`endif
  endtask

  // Called at a falling edge; returns at the next falling edge with outputs checked.
  task automatic step(input bit vld, input bit d, input bit clr);
    din_vld = vld;
    din     = d;
    cnt_clr = clr;
    model_update(vld, d, clr);
    @(negedge clk);
    check_outputs();
    if (m0) pulses[0]++;
    if (m1) pulses[1]++;
    if (m2) pulses[2]++;
  endtask

  task automatic do_reset();
    din_vld = 1'b0;
    cnt_clr = 1'b0;
    rst_n   = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) pulses[i] = 0;
    @(negedge clk);
    model_update(1'b0, 1'b0, 1'b0);
    check_outputs();
  endtask

  task automatic feed(input logic [31:0] bits, input int n);
    logic [31:0] b;
    b = bits;
    for (int k = n - 1; k >= 0; k--) step(1'b1, b[k], 1'b0);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Single pattern: pulse one cycle after the completing bit.
    feed(32'b1011, 4);
    check("tp1_match", 32'(m0), 32'd1);
    check("tp1_fill", 32'(f0), 32'd4);
`ifdef SEQ_DET_CNT_EN
    check("tp1_cnt", 32'(c0), 32'd1);
`endif
    step(1'b0, 1'b0, 1'b0);
    check("tp1_pulse_end", 32'(m0), 32'd0);

    // Overlap vs non-overlap on 1011011.
    do_reset();
    feed(32'b1011011, 7);
    check("tp2_ov_pulses", 32'(pulses[0]), 32'd2);
    check("tp2_no_pulses", 32'(pulses[1]), 32'd1);
    check("tp2_no_fill", 32'(f1), 32'd3);

    // Gaps neither break nor create a match.
    do_reset();
    feed(32'b10, 2);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("tp3_gap_pulses", 32'(pulses[0]), 32'd0);
    feed(32'b11, 2);
    check("tp3_match", 32'(m0), 32'd1);

    // Reset mid-sequence discards history.
    do_reset();
    feed(32'b101, 3);
    do_reset();
    feed(32'b1, 1);
    check("tp4_match", 32'(m0), 32'd0);
    check("tp4_fill", 32'(f0), 32'd1);
`ifdef SEQ_DET_CNT_EN
    check("tp4_cnt", 32'(c0), 32'd0);

    // Counter saturation and clear-over-increment.
    do_reset();
    feed(32'b1011011011011011, 16);
    check("tp5_sat", 32'(c0), 32'd3);
    feed(32'b01, 2);
    step(1'b1, 1'b1, 1'b1);
    check("tp5_clr_match", 32'(m0), 32'd1);
    check("tp5_clr_cnt", 32'(c0), 32'd0);
`endif

    // Randomized stream with gaps, clears and occasional resets.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      else step($urandom_range(0, 4) != 0, 1'($urandom), $urandom_range(0, 29) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
